// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 8;
    // Wait counter only has to reach the largest legal read latency (3).
    localparam int unsigned CNT_W      = 2;

    localparam logic OWN_CPU  = 1'b0;
    localparam logic OWN_HOST = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/dmem_port_arbiter_rr_pick2.sv
// Two-way round-robin select: on a tie, the requester that did not win last time is chosen.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    always_comb begin
        grant_valid = |req;
        grant_id    = OWN_CPU;
        if (req == 2'b11) begin
            grant_id = ~last_grant;
        end else if (req[1]) begin
            grant_id = OWN_HOST;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Serialises CPU and host-loader accesses onto the single-port data memory,
// latching each command at grant and returning read data per requester.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              last_grant
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              host_ack_q, host_ack_d;
    logic              busy_q, busy_d;
    logic              last_grant_q, last_grant_d;

    logic              grant_valid;
    logic              grant_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              rd_capture;

    rr_pick2 u_pick (
        .req         ({host_req, cpu_req}),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign sel_we     = (grant_id == OWN_HOST) ? host_we    : cpu_we;
    assign sel_addr   = (grant_id == OWN_HOST) ? host_addr  : cpu_addr;
    assign sel_wdata  = (grant_id == OWN_HOST) ? host_wdata : cpu_wdata;
    assign rd_capture = (state_q == ST_WAIT) && (cnt_q == CNT_ONE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = LAT_LOAD;
                state_d = we_q ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output / datapath next values; memory strobes are set up at the grant edge
    // so they are registered and valid during ISSUE.
    always_comb begin
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        last_grant_d = last_grant_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        host_rdata_d = host_rdata_q;
        cpu_ack_d    = 1'b0;
        host_ack_d   = 1'b0;
        busy_d       = (state_d != ST_IDLE);

        if ((state_q == ST_IDLE) && grant_valid) begin
            owner_d      = grant_id;
            last_grant_d = grant_id;
            we_d         = sel_we;
            addr_d       = sel_addr;
            wdata_d      = sel_wdata;
            mem_en_d     = 1'b1;
            mem_we_d     = sel_we;
        end

        if (rd_capture) begin
            if (owner_q == OWN_HOST) begin
                host_rdata_d = mem_rdata;
            end else begin
                cpu_rdata_d = mem_rdata;
            end
        end

        if ((state_d == ST_RESP) && (state_q != ST_RESP)) begin
            cpu_ack_d  = (owner_q == OWN_CPU);
            host_ack_d = (owner_q == OWN_HOST);
        end
    end

    // Output and command registers
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q      <= OWN_CPU;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            last_grant_q <= OWN_HOST;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
            cpu_ack_q    <= 1'b0;
            host_ack_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            last_grant_q <= last_grant_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            cpu_rdata_q  <= cpu_rdata_d;
            host_rdata_q <= host_rdata_d;
            cpu_ack_q    <= cpu_ack_d;
            host_ack_q   <= host_ack_d;
            busy_q       <= busy_d;
        end
    end

    assign cpu_rdata  = cpu_rdata_q;
    assign host_rdata = host_rdata_q;
    assign cpu_ack    = cpu_ack_q;
    assign host_ack   = host_ack_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign busy       = busy_q;
    assign last_grant = last_grant_q;
    assign cpu_stall  = cpu_req & ~cpu_ack_q;

    a_ack_onehot: assert property (@(posedge clk) disable iff (rst) !(cpu_ack_q && host_ack_q));
    a_en_in_issue: assert property (@(posedge clk) disable iff (rst) mem_en_q == (state_q == ST_ISSUE));

endmodule
